// File: rtl/noc_input_channel.sv
// Mesh-switch input stage: flit FIFO, head-address latch, allocator request, wormhole forwarding.
// Optional NOC_INPUT_CHANNEL_ERR_EN adds a sticky discard flag and a saturating discard counter.
module noc_input_channel #(
  parameter int DATA_W       = 8,
  parameter int COL_ADDR_W   = 4,
  parameter int ROW_ADDR_W   = 4,
  parameter int OUT_M        = 5,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_W+1:0]     data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [COL_ADDR_W-1:0] col_addr_o,
  output logic [ROW_ADDR_W-1:0] row_addr_o,
  input  logic [OUT_M-1:0]      oc_sel_i,
  output logic [OUT_M-1:0]      oc_req_o,
  input  logic                  grant_i,
  output logic [DATA_W+1:0]     data_o,
  output logic                  valid_o,
  input  logic                  ready_i
`ifdef NOC_INPUT_CHANNEL_ERR_EN
  ,
  output logic                  err_o,
  output logic [7:0]            err_cnt_o
`endif
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;

  logic [DATA_W+1:0] r_mem [BUFFER_DEPTH];
  logic [AW:0]       r_wptr, r_rptr;
  logic [1:0]        r_state;
  logic              r_in_rst;
  logic [COL_ADDR_W-1:0] r_col;
  logic [ROW_ADDR_W-1:0] r_row;

  logic              w_empty, w_full, w_wr, w_rd, w_fwd, w_discard, w_valid;
  logic [DATA_W+1:0] w_head;
  logic [1:0]        w_htype;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  assign w_htype = w_head[DATA_W+1:DATA_W];

  // type[1] marks a packet start (HEAD/SINGLE), type[0] a packet end (TAIL/SINGLE)
  assign w_discard = (r_state == S_IDLE) && !w_empty && !w_htype[1];
  assign w_valid   = (r_state == S_ACT) && !w_empty;
  assign w_fwd     = w_valid && ready_i;
  assign w_rd      = w_fwd || w_discard;
  assign w_wr      = valid_i && ready_o;

  assign ready_o    = !w_full && !r_in_rst;
  assign valid_o    = w_valid;
  assign data_o     = w_valid ? w_head : '0;
  assign oc_req_o   = (r_state == S_WAIT || r_state == S_ACT) ? oc_sel_i : '0;
  assign col_addr_o = r_col;
  assign row_addr_o = r_row;

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_in_rst <= 1'b1;
    end else begin
      r_in_rst <= 1'b0;
      if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Route is held from head latch until the end-of-packet handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (!w_empty && w_htype[1]) begin
          r_col   <= w_head[COL_ADDR_W-1:0];
          r_row   <= w_head[COL_ADDR_W+ROW_ADDR_W-1:COL_ADDR_W];
          r_state <= S_WAIT;
        end
        S_WAIT: if (grant_i) r_state <= S_ACT;
        S_ACT:  if (w_fwd && w_htype[0]) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef NOC_INPUT_CHANNEL_ERR_EN
  logic       r_err;
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_discard) begin
      r_err <= 1'b1;
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_o     = r_err;
  assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_noc_input_channel.sv
// Bench for noc_input_channel: directed latency/boundary cases plus randomized traffic
// against a packet-grammar reference model; XY router at (1,1) modelled in the bench.
module tb_noc_input_channel;
  localparam int DW = 8;
  localparam int OM = 5;
  localparam logic [1:0] T_HEAD = 2'b10, T_BODY = 2'b00, T_TAIL = 2'b01, T_SING = 2'b11;

  logic          clk = 1'b0;
  logic          rst, valid_i, ready_o, grant, ready_i, valid_o;
  logic [DW+1:0] din, dout;
  logic [3:0]    col, row;
  logic [OM-1:0] sel, req;
`ifdef NOC_INPUT_CHANNEL_ERR_EN
  logic          err;
  logic [7:0]    errc;
`endif
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  noc_input_channel #(.DATA_W(DW), .COL_ADDR_W(4), .ROW_ADDR_W(4), .OUT_M(OM), .BUFFER_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(din), .valid_i(valid_i), .ready_o(ready_o),
    .col_addr_o(col), .row_addr_o(row), .oc_sel_i(sel), .oc_req_o(req),
    .grant_i(grant), .data_o(dout), .valid_o(valid_o), .ready_i(ready_i)
`ifdef NOC_INPUT_CHANNEL_ERR_EN
    , .err_o(err), .err_cnt_o(errc)
`endif
  );

  // XY router at (1,1): bit0 local, bit1 N, bit2 S, bit3 E, bit4 W
  function automatic logic [4:0] xy(input logic [3:0] c, input logic [3:0] r);
    if (c > 4'd1) return 5'b01000;
    if (c < 4'd1) return 5'b10000;
    if (r > 4'd1) return 5'b00010;
    if (r < 4'd1) return 5'b00100;
    return 5'b00001;
  endfunction
  assign sel = xy(col, row);

  function automatic logic [DW+1:0] flit(input logic [1:0] t, input logic [3:0] c, input logic [3:0] r);
    return {t, r, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step; @(posedge clk); #1; endtask
  task automatic smp;  @(negedge clk);     endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; valid_i = 1'b0; grant = 1'b0; ready_i = 1'b0; din = '0;
    step; smp;
    chk({tag, "_rst_rdy"},  32'(ready_o), 32'd0);
    chk({tag, "_rst_vld"},  32'(valid_o), 32'd0);
    chk({tag, "_rst_req"},  32'(req), 32'd0);
    chk({tag, "_rst_addr"}, 32'({col, row}), 32'd0);
    chk({tag, "_rst_data"}, 32'(dout), 32'd0);
    step; rst = 1'b0; step; smp;
    chk({tag, "_rel_rdy"},  32'(ready_o), 32'd1);
    step;
  endtask

  // SINGLE to (1,1) with grant tied high: req at +2, flit at +3, req gone at +4
  task automatic single_route(input string tag);
    logic [DW+1:0] f;
    f = flit(T_SING, 4'd1, 4'd1);
    valid_i = 1'b1; din = f; grant = 1'b1; ready_i = 1'b1;
    smp; chk({tag, "_c0_rdy"}, 32'(ready_o), 32'd1); step;
    valid_i = 1'b0; din = '0;
    smp; chk({tag, "_c1_req"}, 32'(req), 32'd0); step;
    smp; chk({tag, "_c2_req"}, 32'(req), 32'd1); chk({tag, "_c2_vld"}, 32'(valid_o), 32'd0); step;
    smp; chk({tag, "_c3_vld"}, 32'(valid_o), 32'd1); chk({tag, "_c3_data"}, 32'(dout), 32'(f)); step;
    smp; chk({tag, "_c4_req"}, 32'(req), 32'd0); chk({tag, "_c4_vld"}, 32'(valid_o), 32'd0); step;
  endtask

  // reference model: accepted flit stream parsed by packet grammar
  logic [DW+1:0] expq[$];
  logic [4:0]    rteq[$];
  bit            m_in_pkt = 0;
  logic [4:0]    m_rt;
  int            m_disc = 0;
  bit            g_in_pkt = 0;

  task automatic model_push(input logic [DW+1:0] f);
    logic [1:0] t;
    t = f[DW+1:DW];
    if (!m_in_pkt) begin
      if (t == T_HEAD || t == T_SING) begin
        m_rt = xy(f[3:0], f[7:4]);
        expq.push_back(f); rteq.push_back(m_rt);
        m_in_pkt = (t == T_HEAD);
      end else m_disc++;
    end else begin
      expq.push_back(f); rteq.push_back(m_rt);
      if (t == T_TAIL || t == T_SING) m_in_pkt = 0;
    end
  endtask

  function automatic logic [DW+1:0] gen();
    logic [3:0] c, r;
    c = 4'($urandom_range(0, 3));
    r = 4'($urandom_range(0, 3));
    if (!g_in_pkt) begin
      if ($urandom_range(0, 99) < 8) return {($urandom_range(0, 1) != 0) ? T_TAIL : T_BODY, 8'($urandom)};
      if ($urandom_range(0, 99) < 30) return flit(T_SING, c, r);
      g_in_pkt = 1;
      return flit(T_HEAD, c, r);
    end
    if ($urandom_range(0, 99) < 30) begin
      g_in_pkt = 0;
      return {T_TAIL, 8'($urandom)};
    end
    return {T_BODY, 8'($urandom)};
  endfunction

  task automatic check_out(input string tag);
    if (valid_o && ready_i) begin
      if (expq.size() == 0) chk({tag, "_extra"}, 32'd1, 32'd0);
      else begin
        chk({tag, "_data"}, 32'(dout), 32'(expq.pop_front()));
        chk({tag, "_req"},  32'(req),  32'(rteq.pop_front()));
      end
    end
  endtask

  initial begin
    logic [DW+1:0] p[5];
    logic [DW+1:0] pend;
    int cyc;

    rst = 1'b1; valid_i = 1'b0; grant = 1'b0; ready_i = 1'b0; din = '0;
    do_reset("init");

    single_route("t1");

    // HEAD/BODY/BODY/TAIL streamed back to back toward east
    p[0] = flit(T_HEAD, 4'd3, 4'd1); p[1] = {T_BODY, 8'hA5}; p[2] = {T_BODY, 8'h3C}; p[3] = {T_TAIL, 8'h7E};
    grant = 1'b1; ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      valid_i = (c < 4); din = (c < 4) ? p[c] : '0;
      smp;
      chk($sformatf("t2_req%0d", c), 32'(req), (c >= 2 && c <= 6) ? 32'h8 : 32'h0);
      chk($sformatf("t2_vld%0d", c), 32'(valid_o), (c >= 3 && c <= 6) ? 32'd1 : 32'd0);
      if (c >= 3 && c <= 6) chk($sformatf("t2_data%0d", c), 32'(dout), 32'(p[c-3]));
      step;
    end

    // fill to depth with grant withheld; fifth flit must be refused
    p[4] = flit(T_SING, 4'd1, 4'd1);
    grant = 1'b0; ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      valid_i = 1'b1; din = p[c];
      smp; chk($sformatf("t3_rdy%0d", c), 32'(ready_o), (c < 4) ? 32'd1 : 32'd0); step;
    end
    valid_i = 1'b0; din = '0; grant = 1'b1;
    for (int c = 5; c < 14; c++) begin
      smp;
      chk($sformatf("t3_req%0d", c), 32'(req), (c <= 9) ? 32'h8 : 32'h0);
      chk($sformatf("t3_vld%0d", c), 32'(valid_o), (c >= 6 && c <= 9) ? 32'd1 : 32'd0);
      if (c >= 6 && c <= 9) chk($sformatf("t3_data%0d", c), 32'(dout), 32'(p[c-6]));
      step;
    end

    // stray BODY discarded, then SINGLE routed south
    p[0] = {T_BODY, 8'h55}; p[1] = flit(T_SING, 4'd1, 4'd0);
    grant = 1'b1; ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      valid_i = (c < 2); din = (c < 2) ? p[c] : '0;
      smp;
      chk($sformatf("t4_req%0d", c), 32'(req), (c == 3 || c == 4) ? 32'h4 : 32'h0);
      chk($sformatf("t4_vld%0d", c), 32'(valid_o), (c == 4) ? 32'd1 : 32'd0);
      if (c == 4) chk("t4_data", 32'(dout), 32'(p[1]));
`ifdef NOC_INPUT_CHANNEL_ERR_EN
      chk($sformatf("t4_err%0d", c),  32'(err),  (c >= 2) ? 32'd1 : 32'd0);
      chk($sformatf("t4_errc%0d", c), 32'(errc), (c >= 2) ? 32'd1 : 32'd0);
`endif
      step;
    end

    // reset while a packet is active with data still queued
    p[0] = flit(T_HEAD, 4'd3, 4'd1); p[1] = {T_BODY, 8'h11}; p[2] = {T_BODY, 8'h22};
    grant = 1'b1; ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      valid_i = (c < 3); din = (c < 3) ? p[c] : '0;
      smp;
      if (c == 4) begin
        chk("t6_pre_vld", 32'(valid_o), 32'd1);
        chk("t6_pre_req", 32'(req), 32'h8);
      end
      step;
    end
    do_reset("t6");
    single_route("t6b");

    // randomized traffic against the packet-grammar model
    do_reset("rnd");
    m_in_pkt = 0; m_disc = 0; g_in_pkt = 0;
    pend = gen();
    for (int c = 0; c < 3000; c++) begin
      valid_i = ($urandom_range(0, 9) < 7);
      din     = valid_i ? pend : '0;
      ready_i = ($urandom_range(0, 9) < 7);
      grant   = ($urandom_range(0, 1) != 0);
      smp;
      check_out("rnd");
      if (valid_i && ready_o) begin
        model_push(pend);
        pend = gen();
      end
      step;
    end
    valid_i = 1'b0; din = '0; ready_i = 1'b1; grant = 1'b1;
    cyc = 0;
    while (expq.size() > 0 && cyc < 300) begin
      smp; check_out("drn"); step;
      cyc++;
    end
    chk("rnd_drain", 32'(expq.size()), 32'd0);
    for (int c = 0; c < 8; c++) step;
`ifdef NOC_INPUT_CHANNEL_ERR_EN
    smp;
    chk("rnd_errc", 32'(errc), 32'((m_disc > 255) ? 255 : m_disc));
    chk("rnd_err",  32'(err),  (m_disc > 0) ? 32'd1 : 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
